// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the iterative multiply/divide unit.
interface muldiv_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        wb_en;

   modport master (
      output start, funct3, op_a, op_b, rd_in,
      input  busy, done, result, rd_out, wb_en
   );

   modport slave (
      input  start, funct3, op_a, op_b, rd_in,
      output busy, done, result, rd_out, wb_en
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per CALC cycle.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and multiply-by-zero go straight from IDLE to DONE.
module muldiv_unit (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t                     state, state_nxt;
   logic [4:0]                 cnt;
   logic                       accept, last_iter, fast_hit, busy_w, done_w;
   logic [DATA_W-1:0]          result_q;
   logic [4:0]                 rd_out_q, rd_q;
   logic [2:0]                 f3_q;
   logic                       b_sgn_q, neg_q, neg_r, div_zero_q, div_ovf_q;
   logic [DATA_W-1:0]          op_a_q, mplier;
   logic [2*DATA_W-1:0]        acc, mcand, acc_nxt;
   logic [DATA_W:0]            rem_shift;
   logic [DATA_W-1:0]          rem_sub;
   logic                       a_sgn, b_sgn, sdiv, div_zero, div_ovf;
   logic [DATA_W-1:0]          a_mag, b_mag;
   logic signed [2*DATA_W-1:0] a_ext;

   // Final sign fix-up and the fixed answers for divide-by-zero and signed overflow.
   function automatic logic [DATA_W-1:0] fmt_result(
      input logic [2:0]          f3,
      input logic [2*DATA_W-1:0] r,
      input logic                nq,
      input logic                nr,
      input logic                dz,
      input logic                ov,
      input logic [DATA_W-1:0]   a
   );
      logic [DATA_W-1:0] lo, hi;
      lo = r[DATA_W-1:0];
      hi = r[2*DATA_W-1:DATA_W];
      case (f3)
         3'b000:                 return lo;
         3'b001, 3'b010, 3'b011: return hi;
         3'b100, 3'b101:         return dz ? '1 : (ov ? 32'h8000_0000 : (nq ? -lo : lo));
         default:                return dz ? a : (ov ? '0 : (nr ? -hi : hi));
      endcase
   endfunction

   always_comb begin
      sdiv     = bus.funct3[2] & ~bus.funct3[0];
      a_sgn    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
      b_sgn    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
      a_ext    = {{DATA_W{a_sgn & bus.op_a[DATA_W-1]}}, bus.op_a};
      a_mag    = (sdiv && bus.op_a[DATA_W-1]) ? -bus.op_a : bus.op_a;
      b_mag    = (sdiv && bus.op_b[DATA_W-1]) ? -bus.op_b : bus.op_b;
      div_zero = (bus.op_b == '0);
      div_ovf  = sdiv && (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
   end

`ifdef MULDIV_FAST_SPECIAL_EN
   assign fast_hit = bus.funct3[2] ? (div_zero | div_ovf) : ((bus.op_a == '0) | div_zero);
`else
   assign fast_hit = 1'b0;
`endif

   assign accept    = (state == IDLE) && bus.start;
   assign last_iter = (state == CALC) && (cnt == 5'd31);

   // One iteration: bit 31 of a signed multiplier carries weight -2^31, hence subtract.
   always_comb begin
      rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      rem_sub   = rem_shift[DATA_W-1:0] - mcand[DATA_W-1:0];
      acc_nxt   = acc;
      if (!f3_q[2]) begin
         if (mplier[0]) acc_nxt = (cnt == 5'd31 && b_sgn_q) ? acc - mcand : acc + mcand;
      end else if (rem_shift >= {1'b0, mcand[DATA_W-1:0]}) begin
         acc_nxt = {rem_sub, acc[DATA_W-2:0], 1'b1};
      end else begin
         acc_nxt = {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = fast_hit ? DONE : CALC;
         CALC:    if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_w = (state != IDLE);
      done_w = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         if (accept)              cnt <= '0;
         else if (state == CALC)  cnt <= cnt + 5'd1;
         if (accept && fast_hit) begin
            result_q <= fmt_result(bus.funct3, '0, 1'b0, 1'b0, div_zero, div_ovf, bus.op_a);
            rd_out_q <= bus.rd_in;
         end else if (last_iter) begin
            result_q <= fmt_result(f3_q, acc_nxt, neg_q, neg_r, div_zero_q, div_ovf_q, op_a_q);
            rd_out_q <= rd_q;
         end
      end
   end

   // Operand capture; divide keeps {remainder, quotient} in acc and the divisor magnitude in mcand.
   always_ff @(posedge clk) begin
      if (accept) begin
         f3_q       <= bus.funct3;
         rd_q       <= bus.rd_in;
         op_a_q     <= bus.op_a;
         b_sgn_q    <= b_sgn;
         neg_q      <= sdiv & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
         neg_r      <= sdiv & bus.op_a[DATA_W-1];
         div_zero_q <= div_zero;
         div_ovf_q  <= div_ovf;
         mplier     <= bus.op_b;
         if (bus.funct3[2]) begin
            acc   <= {{DATA_W{1'b0}}, a_mag};
            mcand <= {{DATA_W{1'b0}}, b_mag};
         end else begin
            acc   <= '0;
            mcand <= a_ext;
         end
      end else if (state == CALC) begin
         acc    <= acc_nxt;
         mplier <= mplier >> 1;
         if (!f3_q[2]) mcand <= mcand << 1;
      end
   end

   assign bus.busy   = busy_w;
   assign bus.done   = done_w;
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;
   assign bus.wb_en  = done_w & (rd_out_q != '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle compare plus directed RV32M vectors.
module tb_muldiv_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   muldiv_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef MULDIV_FAST_SPECIAL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int LAT_SP = FAST ? 1 : 33;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   bit          chk_en   = 1'b0;
   int          m_left   = 0;
   bit          m_done   = 1'b0;
   logic [31:0] m_result = '0;
   logic [31:0] p_res    = '0;
   logic [4:0]  m_rd     = '0;
   logic [4:0]  p_rd     = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      bit     ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2]) return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      return (a == 32'd0) || (b == 32'd0);
   endfunction

   // Reference timeline: 32 CALC cycles then one DONE cycle, or DONE at once for fast special cases.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left   <= 0;
         m_done   <= 1'b0;
         m_result <= '0;
         m_rd     <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done   <= 1'b1;
            m_result <= p_res;
            m_rd     <= p_rd;
         end
      end else if (bus.start) begin
         if (FAST && is_special(bus.funct3, bus.op_a, bus.op_b)) begin
            m_done   <= 1'b1;
            m_result <= ref_result(bus.funct3, bus.op_a, bus.op_b);
            m_rd     <= bus.rd_in;
         end else begin
            m_left <= 32;
            p_res  <= ref_result(bus.funct3, bus.op_a, bus.op_b);
            p_rd   <= bus.rd_in;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc busy", 32'(bus.busy), 32'((m_left > 0) || m_done));
         check("cyc done", 32'(bus.done), 32'(m_done));
         check("cyc wb_en", 32'(bus.wb_en), 32'(m_done && (m_rd != 5'd0)));
         if (m_done) begin
            check("cyc result", bus.result, m_result);
            check("cyc rd_out", 32'(bus.rd_out), 32'(m_rd));
         end
      end
   end

   task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat, input int repulse_at);
      int lat;
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.rd_in  = rd;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.op_a   = ~a;
      bus.op_b   = a ^ b;
      bus.funct3 = ~f;
      bus.rd_in  = ~rd;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (lat == repulse_at) begin
            bus.start  = 1'b1;
            bus.funct3 = 3'd0;
            bus.op_a   = 32'h1234_5678;
            bus.op_b   = 32'h0000_0003;
            bus.rd_in  = 5'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, bus.result, exp_res);
      check({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
      check({name, " wb_en"}, 32'(bus.wb_en), 32'(rd != 5'd0));
      @(posedge clk); #1;
      check({name, " idle after"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done;
      bus.start  = 1'b0;
      bus.funct3 = 3'd0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus.rd_in  = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset wb_en", 32'(bus.wb_en), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset rd_out", 32'(bus.rd_out), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      check("model mul", ref_result(3'd0, 32'h0000_0007, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      check("model mulhu", ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("model mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'h0000_0002), 32'hFFFF_FFFF);
      check("model div", ref_result(3'd4, 32'hFFFF_FFF9, 32'h0000_0002), 32'hFFFF_FFFD);
      check("model rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'h0000_0002), 32'hFFFF_FFFF);
      check("model remu0", ref_result(3'd7, 32'h8000_0000, 32'h0000_0000), 32'h8000_0000);

      @(posedge clk); #1;
      do_op("mul",         3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0);
      do_op("mulhu",       3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33, 0);
      do_op("mulhsu",      3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2,  32'hFFFF_FFFF, 33, 0);
      do_op("mulh min",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33, 0);
      do_op("mulh neg",    3'd1, 32'hFFFF_FFFF, 32'h0000_0005, 5'd4,  32'hFFFF_FFFF, 33, 0);
      do_op("div",         3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFD, 33, 0);
      do_op("rem",         3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF, 33, 0);
      do_op("divu by0",    3'd5, 32'h8000_0000, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, LAT_SP, 0);
      do_op("remu by0",    3'd7, 32'h8000_0000, 32'h0000_0000, 5'd9,  32'h8000_0000, LAT_SP, 0);
      do_op("div ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, LAT_SP, 0);
      do_op("rem ovf rd0", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, LAT_SP, 0);
      do_op("div by0 s",   3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 5'd11, 32'hFFFF_FFFF, LAT_SP, 0);
      do_op("rem by0 s",   3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd12, 32'hFFFF_FFF9, LAT_SP, 0);
      do_op("mul zero",    3'd0, 32'h0000_0000, 32'h0001_2345, 5'd13, 32'h0000_0000, LAT_SP, 0);
      do_op("divu",        3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 5'd14, 32'h0FFF_FFFF, 33, 0);
      do_op("remu",        3'd7, 32'h0000_0064, 32'h0000_0007, 5'd15, 32'h0000_0002, 33, 0);
      do_op("rem negdiv",  3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd16, 32'h0000_0001, 33, 0);
      do_op("div negneg",  3'd4, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 5'd17, 32'h0000_0005, 33, 0);
      do_op("repulse",     3'd0, 32'h0000_0006, 32'h0000_0007, 5'd18, 32'h0000_002A, 33, 10);

      // Reset in cycle 15 of a running multiply.
      bus.start  = 1'b1;
      bus.funct3 = 3'd0;
      bus.op_a   = 32'h0000_0006;
      bus.op_b   = 32'h0000_0009;
      bus.rd_in  = 5'd15;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset busy", 32'(bus.busy), 32'd0);
      check("midreset result", bus.result, 32'd0);
      check("midreset rd_out", 32'(bus.rd_out), 32'd0);
      check("midreset done", 32'(bus.done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("no done after reset", 32'(saw_done), 32'd0);
      do_op("after reset", 3'd0, 32'h0000_0006, 32'h0000_0009, 5'd15, 32'h0000_0036, 33, 0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
